// File: rtl/device_delay_timer.sv
// Millisecond delay generator: counts DELAY_MS milliseconds of clk_i after reset
// or after a synchronous restart request, then raises a sticky delay_done flag.
module device_delay_timer #(
  parameter int unsigned CLK_FREQ_HZ = 27000000,
  parameter int unsigned DELAY_MS    = 10
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic syn_rst,
  output logic delay_done
);

  localparam int unsigned TICKS_PER_MS = CLK_FREQ_HZ / 1000;
  localparam int unsigned PS_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int unsigned MS_W = (DELAY_MS > 0) ? $clog2(DELAY_MS + 1) : 1;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_MS - 1);
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(DELAY_MS - 1);
  localparam logic [MS_W-1:0] MS_TERM = MS_W'(DELAY_MS);

  if (CLK_FREQ_HZ < 1000) begin : g_bad_clk_freq
    $error("device_delay_timer: CLK_FREQ_HZ must be >= 1000");
  end
  if (DELAY_MS < 1) begin : g_bad_delay_ms
    $error("device_delay_timer: DELAY_MS must be >= 1");
  end

  typedef enum logic {
    COUNTING = 1'b0,
    DONE     = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [PS_W-1:0] ps_reg, ps_next;
  logic [MS_W-1:0] ms_reg, ms_next;
  logic            done_reg, done_next;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= COUNTING;
      ps_reg    <= '0;
      ms_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ps_reg    <= ps_next;
      ms_reg    <= ms_next;
      done_reg  <= done_next;
    end
  end

  // Restart wins over both counting and the final DONE transition.
  always_comb begin
    state_next = state_reg;
    ps_next    = ps_reg;
    ms_next    = ms_reg;
    done_next  = done_reg;
    if (syn_rst) begin
      state_next = COUNTING;
      ps_next    = '0;
      ms_next    = '0;
      done_next  = 1'b0;
    end else begin
      case (state_reg)
        COUNTING: begin
          if (ps_reg == PS_LAST) begin
            ps_next = '0;
            if (ms_reg == MS_LAST) begin
              ms_next    = MS_TERM;
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              ms_next = ms_reg + MS_W'(1);
            end
          end else begin
            ps_next = ps_reg + PS_W'(1);
          end
        end
        DONE: begin
          done_next = 1'b1;
        end
        default: begin
          state_next = COUNTING;
        end
      endcase
    end
  end

  assign delay_done = done_reg;

endmodule

// File: tb/tb_device_delay_timer.sv
// Bench for device_delay_timer: two instances checked each cycle against an
// edge-count model (done once N edges have passed since reset or the last restart).
module tb_device_delay_timer;

  localparam int unsigned N_A = 3 * (4000 / 1000);  // 12
  localparam int unsigned N_B = 2 * (5999 / 1000);  // 10, remainder discarded
  localparam int unsigned SAT = 1000;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  logic syn_rst = 1'b0;
  logic done_a, done_b;

  int n_cmp = 0;
  int n_err = 0;
  int since_a = 0;
  int since_b = 0;

  always #5 clk_i = ~clk_i;

  device_delay_timer #(.CLK_FREQ_HZ(4000), .DELAY_MS(3)) u_dut_a (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .syn_rst    (syn_rst),
    .delay_done (done_a)
  );

  device_delay_timer #(.CLK_FREQ_HZ(5999), .DELAY_MS(2)) u_dut_b (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .syn_rst    (syn_rst),
    .delay_done (done_b)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_a"}, done_a, (since_a >= int'(N_A)));
    check({tag, "_b"}, done_b, (since_b >= int'(N_B)));
  endtask

  // One clock edge with rst_n high; model advances per the edge-count rule.
  task automatic step(input logic sr, input string tag);
    syn_rst = sr;
    @(posedge clk_i);
    if (sr) begin
      since_a = 0;
      since_b = 0;
    end else begin
      if (since_a < int'(SAT)) since_a++;
      if (since_b < int'(SAT)) since_b++;
    end
    @(negedge clk_i);
    check_both(tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    since_a = 0;
    since_b = 0;
    check_both(tag);
    @(negedge clk_i);
    @(negedge clk_i);
    check_both({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_i);
    check_both("reset_state");
    rst_n = 1'b1;

    // Power-up: done after exactly N edges, then sticky
    for (int i = 0; i < 14; i++) step(1'b0, "powerup");
    check("powerup_done_a", done_a, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b0, "sticky");

    // Restart from DONE with a one-cycle pulse
    step(1'b1, "restart_pulse");
    check("restart_drop_a", done_a, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, "restart_count");

    // Restart mid-count at edge 7 after an async reset
    async_reset("async_pre_mid");
    for (int i = 0; i < 6; i++) step(1'b0, "mid_pre");
    step(1'b1, "mid_pulse");
    for (int i = 0; i < 14; i++) step(1'b0, "mid_post");
    check("mid_done_a", done_a, 1'b1);

    // Held restart for 20 edges
    for (int i = 0; i < 20; i++) step(1'b1, "held_high");
    for (int i = 0; i < 14; i++) step(1'b0, "held_release");

    // Async reset while in DONE
    check("before_async_a", done_a, 1'b1);
    async_reset("async_done");
    for (int i = 0; i < 14; i++) step(1'b0, "async_recount");

    // Randomized restart pulses, bursts and occasional async resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset("rand_async");
      end else begin
        step(($urandom_range(0, 24) == 0), "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
